// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial feeder for the deserializer/queue.
// Takes bytes over a valid/ready handshake and replays each one MSB-first as
// data_out/write_out bit strobes, one bit every BIT_PERIOD clocks.
// Optional build macro: BYTE_SERIALIZER_STALL_EN -- when defined, hold_in
// also freezes the slot counter of a byte already in flight.
module byte_serializer #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clock_1M,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       hold_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic [3:0] bits_left
);

  localparam int CNT_W = $clog2(BIT_PERIOD);
  // Counter is loaded with BIT_PERIOD-2 so that SLOT plus the one STROBE
  // cycle together span exactly BIT_PERIOD clocks.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_PERIOD - 2);

  typedef enum logic [1:0] {
    IDLE,
    SLOT,
    STROBE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic [3:0]       bits;
  logic [3:0]       bits_nxt;
  logic             slot_frozen;

`ifdef BYTE_SERIALIZER_STALL_EN
  // Downstream full pauses the slot timer; a strobe in progress is not cut.
  assign slot_frozen = hold_in;
`else
  // Downstream full only gates acceptance; bytes in flight run to completion.
  assign slot_frozen = 1'b0;
`endif

  // State, slot counter, shift register and bit count; reset aborts a byte.
  always_ff @(posedge clock_1M or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
      bits  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shift <= shift_nxt;
      bits  <= bits_nxt;
    end
  end

  // Next-state logic: accept, count down the slot, strobe and shift.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    bits_nxt  = bits;
    case (state)
      IDLE: begin
        if (byte_valid && !hold_in) begin
          shift_nxt = byte_in;
          bits_nxt  = 4'd8;
          cnt_nxt   = RELOAD;
          state_nxt = SLOT;
        end
      end
      SLOT: begin
        if (!slot_frozen) begin
          if (cnt == '0) begin
            state_nxt = STROBE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      STROBE: begin
        shift_nxt = {shift[6:0], 1'b0};
        bits_nxt  = bits - 4'd1;
        if (bits == 4'd1) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = RELOAD;
          state_nxt = SLOT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign byte_ready = (state == IDLE) && !hold_in;
  assign write_out  = (state == STROBE);
  assign busy_out   = (state != IDLE);
  assign data_out   = shift[7];
  assign bits_left  = bits;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: per-cycle comparison against a
// timeline model (elapsed slot time since accept), a table of single-byte
// transactions, directed multi-cycle corner cases and random traffic.
module tb_byte_serializer;

  localparam int BP = 10;
`ifdef BYTE_SERIALIZER_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       hold_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic [3:0] bits_left;

  always #5 clk = ~clk;

  byte_serializer #(.BIT_PERIOD(BP)) dut (
    .clock_1M  (clk),
    .reset     (rst_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .hold_in   (hold_in),
    .data_out  (data_out),
    .write_out (write_out),
    .busy_out  (busy_out),
    .bits_left (bits_left)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  // Model: a byte in flight is described only by the slot time elapsed since
  // its accept edge (m_d); bit k owns slot time [k*BP, (k+1)*BP).
  bit         m_busy = 1'b0;
  int         m_d = 0;
  logic [7:0] m_byte = '0;
  int         acc_cnt = 0;
  int         last_acc = 0;
  bit         sq[$];
  int         sc[$];

  typedef struct {
    logic [7:0] b;
    logic [7:0] exp_bits;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    int k;
    bit e_strobe;
    bit e_data;
    int e_bits;
    k        = m_d / BP;
    e_strobe = m_busy && ((m_d % BP) == BP - 1);
    e_data   = 1'b0;
    e_bits   = 0;
    if (m_busy && k <= 7) begin
      e_data = m_byte[7 - k];
      e_bits = 8 - k;
    end
    chk("write_out", write_out, e_strobe);
    chk("data_out", data_out, e_data);
    chk("busy_out", busy_out, m_busy);
    chk("bits_left", bits_left, e_bits);
    chk("byte_ready", byte_ready, !m_busy && !hold_in);
    if (write_out === 1'b1) begin
      sq.push_back(data_out);
      sc.push_back(cyc);
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling.
  task automatic tick();
    bit strobe_now;
    @(posedge clk);
    cyc++;
    if (rst_n !== 1'b1) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      strobe_now = (m_d % BP) == BP - 1;
      if (!(STALL && hold_in && !strobe_now)) m_d++;
      if (m_d >= 8 * BP) m_busy = 1'b0;
    end else if (byte_valid && !hold_in) begin
      m_busy   = 1'b1;
      m_d      = 0;
      m_byte   = byte_in;
      acc_cnt++;
      last_acc = cyc;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int start;
    start      = acc_cnt;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int i = 0; i < 300 && acc_cnt == start; i++) tick();
    byte_valid = 1'b0;
    chk("accept_timeout", acc_cnt - start, 1);
  endtask

  task automatic run_idle();
    for (int i = 0; i < 1000 && m_busy; i++) tick();
    chk("idle_timeout", m_busy, 0);
  endtask

  function automatic logic [15:0] pattern();
    logic [15:0] p;
    p = '0;
    foreach (sq[i]) p = {p[14:0], sq[i]};
    return p;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int e0;
    tbl[0] = '{8'h11, 8'b0001_0001, BP - 1, 8 * BP - 1};
    tbl[1] = '{8'h80, 8'b1000_0000, BP - 1, 8 * BP - 1};
    tbl[2] = '{8'h01, 8'b0000_0001, BP - 1, 8 * BP - 1};
    tbl[3] = '{8'h6C, 8'b0110_1100, BP - 1, 8 * BP - 1};

    rst_n      = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    hold_in    = 1'b0;
    #2;
    check_outputs();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single bytes from the table
    for (int i = 0; i < 4; i++) begin
      sq.delete();
      sc.delete();
      send_byte(tbl[i].b);
      run_idle();
      chk("tbl_busy_fall", cyc - last_acc, 8 * BP);
      chk("tbl_nstrobe", sq.size(), 8);
      chk("tbl_bits", pattern(), {8'h00, tbl[i].exp_bits});
      if (sc.size() == 8) begin
        chk("tbl_first", sc[0] - last_acc, tbl[i].exp_first);
        chk("tbl_last", sc[7] - last_acc, tbl[i].exp_last);
        for (int k = 1; k < 8; k++) chk("tbl_spacing", sc[k] - sc[k-1], BP);
      end
      tick();
    end

    // Back-to-back 0xAA then 0xFF with byte_valid held
    sq.delete();
    sc.delete();
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    a0 = acc_cnt;
    for (int i = 0; i < 50 && acc_cnt == a0; i++) tick();
    e0 = last_acc;
    byte_in = 8'hFF;
    for (int i = 0; i < 200 && acc_cnt == a0 + 1; i++) tick();
    byte_valid = 1'b0;
    chk("b2b_accepts", acc_cnt - a0, 2);
    chk("b2b_second_accept", last_acc - e0, 8 * BP + 1);
    run_idle();
    chk("b2b_nstrobe", sq.size(), 16);
    chk("b2b_bits", pattern(), 16'hAAFF);
    chk("b2b_data_after", data_out, 1'b0);

    // hold_in high while idle with byte_valid asserted
    sq.delete();
    sc.delete();
    hold_in    = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h3C;
    a0 = acc_cnt;
    repeat (30) tick();
    chk("hold_idle_ready", byte_ready, 1'b0);
    chk("hold_idle_nstrobe", sq.size(), 0);
    chk("hold_idle_busy", busy_out, 1'b0);
    hold_in = 1'b0;
    tick();
    chk("hold_release_accept", acc_cnt - a0, 1);
    chk("hold_release_edge", last_acc, cyc);
    byte_valid = 1'b0;
    run_idle();
    chk("hold_release_nstrobe", sq.size(), 8);
    if (sc.size() > 0) chk("hold_release_first", sc[0] - last_acc, BP - 1);

    // 25-cycle hold_in pulse while a byte is in flight
    sq.delete();
    sc.delete();
    tick();
    send_byte(8'hC3);
    repeat (BP + 2) tick();
    hold_in = 1'b1;
    repeat (25) tick();
    hold_in = 1'b0;
    run_idle();
    chk("midhold_nstrobe", sq.size(), 8);
    chk("midhold_bits", pattern(), 16'h00C3);
    if (sc.size() == 8) begin
      chk("midhold_bit1", sc[1] - last_acc, 2 * BP - 1 + (STALL ? 25 : 0));
      chk("midhold_last", sc[7] - last_acc, 8 * BP - 1 + (STALL ? 25 : 0));
    end

    // Asynchronous reset mid-slot after bit 3 of 0xA5
    sq.delete();
    sc.delete();
    tick();
    send_byte(8'hA5);
    repeat (4 * BP + 3) tick();
    chk("rst_pre_bits", bits_left, 4'd4);
    rst_n = 1'b0;
    #1;
    m_busy = 1'b0;
    chk("rst_async_write", write_out, 1'b0);
    chk("rst_async_data", data_out, 1'b0);
    chk("rst_async_busy", busy_out, 1'b0);
    chk("rst_async_bits", bits_left, 4'd0);
    tick();
    rst_n = 1'b1;
    repeat (2 * BP) tick();
    chk("rst_ready", byte_ready, 1'b1);
    chk("rst_nstrobe", sq.size(), 4);

    // Asynchronous reset during a strobe cycle
    send_byte(8'hFF);
    repeat (BP - 1) tick();
    chk("rst2_pre_write", write_out, 1'b1);
    rst_n = 1'b0;
    #1;
    m_busy = 1'b0;
    chk("rst2_async_write", write_out, 1'b0);
    chk("rst2_async_data", data_out, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      byte_valid = ($urandom_range(0, 3) != 0);
      byte_in    = 8'($urandom);
      if ($urandom_range(0, 19) == 0) hold_in = ~hold_in;
      tick();
    end
    hold_in    = 1'b0;
    byte_valid = 1'b0;
    run_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Upstream feeder for the deserializer/queue top level. Accepts parallel bytes over a valid/ready handshake and replays each one MSB-first as a stream of `data_in`/`write_in` bit strobes, paced at one bit every `BIT_PERIOD` clocks of `clock_1M` (100 kHz default). The deserializer's queue-full `status_out` throttles it through `hold_in`, so no byte is started that the queue cannot absorb.

## Interface
- `BIT_PERIOD`, 10, clocks per bit slot; legal range 2..255; counter width is `$clog2(BIT_PERIOD)`.

- `clock_1M`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `byte_in`  in  8  byte to send; sampled on the accept edge only.
- `byte_valid`  in  1  producer has a byte on `byte_in`.
- `byte_ready`  out  1  block can accept a byte this cycle.
- `hold_in`  in  1  downstream full; driven from deserializer `status_out`.
- `data_out`  out  1  serial bit; connects to deserializer `data_in`.
- `write_out`  out  1  one-clock bit strobe; connects to deserializer `write_in`.
- `busy_out`  out  1  a byte is in flight.
- `bits_left`  out  4  bits of the current byte not yet strobed (8..0).

## Operation
- States:
  - IDLE: no byte in flight.
  - SLOT: slot counter running.
  - STROBE: `write_out`=1 for exactly one clock.
- Reset: state IDLE; shift register, slot counter and `bits_left` = 0; outputs `data_out`=0, `write_out`=0, `busy_out`=0, `bits_left`=0. `byte_ready` follows its combinational rule and is 1 whenever `hold_in`=0.
- `byte_ready` = (state==IDLE) && !`hold_in`. It is combinational from `hold_in`.
- Accept occurs on an edge where `byte_valid` && `byte_ready`. On accept:
  - shift register ← `byte_in`;
  - `bits_left` ← 8;
  - slot counter ← `BIT_PERIOD`-2;
  - state → SLOT.
- SLOT: decrement the counter each clock. At 0, go to STROBE.
- STROBE: `write_out`=1 for one clock. On the edge leaving STROBE:
  - shift left, inserting 0;
  - `bits_left` decrements.
  - If `bits_left` becomes 0, go to IDLE. Otherwise reload the counter with `BIT_PERIOD`-2 and go to SLOT.
- `data_out` = shift register MSB. It is stable for the whole slot, including the strobe cycle, and is 0 in IDLE after a byte completes.
- `busy_out` = (state != IDLE).
- `hold_in` only gates acceptance. A byte already started always completes (see Configuration for the alternative).
- Reset asserted mid-byte aborts the byte immediately, with no further strobes. The partial byte is not resent.

## Timing
- Accept edge = E0.
- Bit k (k=0..7, MSB first) strobes during the cycle starting at edge E0+(k+1)·`BIT_PERIOD`-1 and ending at E0+(k+1)·`BIT_PERIOD`.
- Strobe spacing is exactly `BIT_PERIOD` clocks.
- Last strobe ends at E0+8·`BIT_PERIOD`. IDLE is entered there, and `byte_ready` is high in the following cycle if `hold_in`=0.
- Back-to-back throughput with `byte_valid` held high: the next accept edge is E0+8·`BIT_PERIOD`+1, i.e. one idle cycle between bytes.
- `byte_valid` arriving in the same cycle that `hold_in` rises is not accepted.
- `byte_valid` dropping before accept leaves no state change.

## Configuration
- `BYTE_SERIALIZER_STALL_EN` defined:
  - `hold_in`=1 in SLOT freezes the slot counter, so every later strobe shifts by the number of held cycles.
  - STROBE is never cut short: a strobe already asserted completes its one clock.
  - `busy_out` stays 1 while frozen.
- Not defined: `hold_in` is ignored outside IDLE (behaviour as in Operation).

## Test plan
- Reset low mid-slot after bit 3 of 0xA5 → `write_out`, `data_out`, `busy_out`, `bits_left` all 0 immediately (asynchronous). After release: IDLE, `byte_ready`=1.
- Send 0x11, `BIT_PERIOD`=10, accept at E0 → exactly 8 strobes, one every 10 clocks, the first in the cycle ending at E0+10. Sampled `data_out` on the strobes = 0,0,0,1,0,0,0,1. `bits_left` steps 8→0. `busy_out` falls at E0+80.
- 0xAA then 0xFF with `byte_valid` held → second accept at E0+81. Strobed pattern = 1,0,1,0,1,0,1,0 then eight 1s. `data_out`=0 after the last strobe.
- `hold_in`=1 while IDLE with `byte_valid`=1 for 30 clocks → `byte_ready`=0 and no strobes. Drop `hold_in` → accept on the next edge, first strobe 10 clocks later.
- Without the macro: `hold_in` pulses high for 25 clocks mid-byte → strobe timing unchanged. With `BYTE_SERIALIZER_STALL_EN`: same stimulus delays all remaining strobes by exactly 25 clocks.
- End-to-end with the deserializer: 9 bytes sent, no dequeue → 8 bytes queued, `len_out`=8. The 9th is never accepted because `byte_ready` stays 0 while `status_out`=1.
